// File: rtl/countdown_timer.sv
// countdown_timer: M:SS.d down-counter with a latched alarm at zero.
// Digits are kept in a 4-entry BCD array:
//   [0] tenths, [1] seconds, [2] tens of seconds, [3] minutes.
// A prescaler that runs only in RUN divides clk down to the tenth-second tick.
// Because the prescaler holds its value across a pause, a stop/start pair
// neither drops nor repeats a tick.
module countdown_timer #(
    parameter int TICK_DIV = 1,
    parameter int PRESC_W  = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] set_min0,
    input  logic [3:0] set_sec1,
    input  logic [3:0] set_sec0,
    input  logic [3:0] set_milSec0,
    input  logic       start_resume,
    input  logic       stop,
    input  logic       alarm_ack,
    output logic [3:0] min0,
    output logic [3:0] sec1,
    output logic [3:0] sec0,
    output logic [3:0] milSec0,
    output logic       running,
    output logic       alarm
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    localparam logic [PRESC_W-1:0] TICK_LAST = PRESC_W'(TICK_DIV - 1);

    state_t              state_reg, state_next;
    logic [PRESC_W-1:0]  presc_reg, presc_next;
    logic                alarm_reg, alarm_next;
    logic [3:0]          digit_reg  [4];
    logic [3:0]          digit_next [4];

    logic [3:0]          set_digit  [4];
    logic [3:0]          load_digit [4];
    logic [3:0]          dec_digit  [4];
    logic [3:0]          borrow;
    logic [3:0]          digit_zero;
    logic                count_zero;
    logic                count_one;
    logic                tick;

    assign set_digit[0] = set_milSec0;
    assign set_digit[1] = set_sec0;
    assign set_digit[2] = set_sec1;
    assign set_digit[3] = set_min0;

    // The tenths digit always takes the decrement; higher digits only on borrow.
    assign borrow[0] = 1'b1;

    // Per-digit load clamp, borrow-chain decrement and zero detect.
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
        // Tens of seconds wraps at 5; every other digit at 9.
        localparam logic [3:0] MAXV = (gi == 2) ? 4'd5 : 4'd9;

        assign load_digit[gi] = (set_digit[gi] > MAXV) ? MAXV : set_digit[gi];
        assign digit_zero[gi] = (digit_reg[gi] == 4'd0);
        assign dec_digit[gi]  = !borrow[gi]    ? digit_reg[gi] :
                                digit_zero[gi] ? MAXV :
                                                 digit_reg[gi] - 4'd1;
        if (gi < 3) begin : g_borrow
            assign borrow[gi+1] = borrow[gi] & digit_zero[gi];
        end
    end

    assign count_zero = &digit_zero;
    assign count_one  = (digit_reg[0] == 4'd1) && (&digit_zero[3:1]);
    assign tick       = (state_reg == RUN) && (presc_reg == TICK_LAST);

    // Next-state, next-count, prescaler and alarm decisions in priority order.
    always_comb begin
        state_next = state_reg;
        presc_next = presc_reg;
        alarm_next = alarm_reg;
        digit_next = digit_reg;

        if (load) begin
            digit_next = load_digit;
            state_next = IDLE;
            alarm_next = 1'b0;
            presc_next = '0;
        end else begin
            // An acknowledge may be overridden below by a fresh expiry.
            if (alarm_ack) begin
                alarm_next = 1'b0;
            end
            case (state_reg)
                IDLE, PAUSED: begin
                    if (!stop && start_resume) begin
                        if (count_zero) begin
                            state_next = EXPIRED;
                            alarm_next = 1'b1;
                        end else begin
                            state_next = RUN;
                        end
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_next = PAUSED;
                    end else if (tick) begin
                        presc_next = '0;
                        digit_next = dec_digit;
                        if (count_one) begin
                            state_next = EXPIRED;
                            alarm_next = 1'b1;
                        end
                    end else begin
                        presc_next = presc_reg + PRESC_W'(1);
                    end
                end
                EXPIRED: begin
                    // Count is pinned at zero; only load or reset leave here.
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // State, prescaler, alarm and digit registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            presc_reg <= '0;
            alarm_reg <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                digit_reg[i] <= 4'd0;
            end
        end else begin
            state_reg <= state_next;
            presc_reg <= presc_next;
            alarm_reg <= alarm_next;
            for (int i = 0; i < 4; i++) begin
                digit_reg[i] <= digit_next[i];
            end
        end
    end

    assign milSec0 = digit_reg[0];
    assign sec0    = digit_reg[1];
    assign sec1    = digit_reg[2];
    assign min0    = digit_reg[3];
    assign running = (state_reg == RUN);
    assign alarm   = alarm_reg;

endmodule
